// File: rtl/reg_file_sequencer.sv
// Multi-cycle initiator for an 8x8 register file: takes one decoded instruction
// per handshake, reads the sources, executes, and writes the 8-bit result back.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for an instruction; DONE pulses here after a write
// S_READ  | READREG1/2 driven, waiting READ_WAIT cycles for read data
// S_EXEC  | REGOUT1/2 settled; result latched at the closing edge
// S_WRITE | WRITEENABLE high with WRITEREG/WRITEDATA stable
// S_ERR   | illegal opcode dropped; ERROR high for this one cycle
module reg_file_sequencer #(
  parameter int READ_WAIT = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  input  logic [31:0] INSTRUCTION,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  input  logic [7:0]  REGOUT1,
  input  logic [7:0]  REGOUT2,
  output logic [2:0]  WRITEREG,
  output logic [7:0]  WRITEDATA,
  output logic        WRITEENABLE,
  output logic        DONE,
  output logic        ERROR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_ERR
  } state_t;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  state_t     state;
  logic [7:0] opcode;
  logic [1:0] wait_cnt;
  logic [7:0] alu_res;
  logic [7:0] op_in;
  logic       unused_bits;

  assign op_in       = INSTRUCTION[31:24];
  assign unused_bits = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

  // Ready is gated by reset so an instruction can never be accepted on a reset edge.
  assign INSTR_READY = !RESET && (state == S_IDLE);

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_MOV:  alu_res = REGOUT2;
      OP_ADD:  alu_res = REGOUT1 + REGOUT2;
      OP_SUB:  alu_res = REGOUT1 - REGOUT2;
      OP_AND:  alu_res = REGOUT1 & REGOUT2;
      OP_OR:   alu_res = REGOUT1 | REGOUT2;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      opcode      <= '0;
      wait_cnt    <= '0;
      READREG1    <= '0;
      READREG2    <= '0;
      WRITEREG    <= '0;
      WRITEDATA   <= '0;
      WRITEENABLE <= 1'b0;
      DONE        <= 1'b0;
      ERROR       <= 1'b0;
    end else begin
      WRITEENABLE <= 1'b0;
      DONE        <= 1'b0;
      ERROR       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (INSTR_VALID) begin
            opcode <= op_in;
            if (op_in == OP_LOADI) begin
              WRITEREG    <= INSTRUCTION[18:16];
              WRITEDATA   <= INSTRUCTION[7:0];
              WRITEENABLE <= 1'b1;
              state       <= S_WRITE;
            end else if (op_in <= OP_OR) begin
              WRITEREG <= INSTRUCTION[18:16];
              READREG1 <= INSTRUCTION[10:8];
              READREG2 <= INSTRUCTION[2:0];
              wait_cnt <= 2'(READ_WAIT - 1);
              state    <= S_READ;
            end else begin
              ERROR <= 1'b1;
              state <= S_ERR;
            end
          end
        end
        // Terminal count of the read-wait down-counter ends the READ state.
        S_READ: begin
          if (wait_cnt == 2'd0) state <= S_EXEC;
          else                  wait_cnt <= wait_cnt - 2'd1;
        end
        S_EXEC: begin
          WRITEDATA   <= alu_res;
          WRITEENABLE <= 1'b1;
          state       <= S_WRITE;
        end
        S_WRITE: begin
          DONE  <= 1'b1;
          state <= S_IDLE;
        end
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
